// File: rtl/fib_bin2bcd_if.sv
// Handshake bundle between a producer (e.g. the fib engine or a bench) and
// the binary-to-BCD converter: start/bin in, ready/done_tick/bcd out.
interface fib_bin2bcd_if #(
  parameter int W  = 20,
  parameter int ND = 7
);
  logic            start;
  logic [W-1:0]    bin;
  logic            ready;
  logic            done_tick;
  logic [4*ND-1:0] bcd;

  // Producer side: requests conversions and consumes the BCD result.
  modport master (
    output start,
    output bin,
    input  ready,
    input  done_tick,
    input  bcd
  );

  // Converter side.
  modport slave (
    input  start,
    input  bin,
    output ready,
    output done_tick,
    output bcd
  );
endinterface

// File: rtl/fib_bin2bcd.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit
// per clock. Accepts a value on start while idle, publishes the packed BCD
// result together with a one-cycle done_tick after W shift cycles.
module fib_bin2bcd #(
  parameter int W  = 20,
  parameter int ND = 7
) (
  input  logic        clk,
  input  logic        reset,
  fib_bin2bcd_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  // ND digits must be able to hold the largest W-bit value.
  localparam logic [63:0] DEC_RANGE = 64'd10 ** ND;
  localparam logic [63:0] BIN_RANGE = 64'd1 << W;

  generate
    if (DEC_RANGE <= BIN_RANGE) begin : g_bad_nd
      $fatal(1, "fib_bin2bcd: ND too small for W (need 10**ND > 2**W)");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [W-1:0]    shreg_reg, shreg_next;
  logic [4*ND-1:0] digits_reg, digits_next;
  logic [4*ND-1:0] bcd_reg, bcd_next;

  logic [4*ND-1:0] digits_adj;
  logic [4*ND-1:0] digits_shifted;

  // Add-3 correction: any working digit >= 5 would exceed 9 after doubling.
  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_adj
      assign digits_adj[4*gi +: 4] = (digits_reg[4*gi +: 4] >= 4'd5)
                                   ? digits_reg[4*gi +: 4] + 4'd3
                                   : digits_reg[4*gi +: 4];
    end
  endgenerate

  // Corrected digits shifted left one bit, taking in the next binary MSB.
  assign digits_shifted = {digits_adj[4*ND-2:0], shreg_reg[W-1]};

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      shreg_reg  <= '0;
      digits_reg <= '0;
      bcd_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      shreg_reg  <= shreg_next;
      digits_reg <= digits_next;
      bcd_reg    <= bcd_next;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    shreg_next  = shreg_reg;
    digits_next = digits_reg;
    bcd_next    = bcd_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          shreg_next  = bus.bin;
          digits_next = '0;
          count_next  = CW'(W);
          state_next  = OP;
        end
      end
      OP: begin
        digits_next = digits_shifted;
        shreg_next  = {shreg_reg[W-2:0], 1'b0};
        count_next  = count_reg - 1'b1;
        // The last shift lands directly in the output register.
        if (count_reg == CW'(1)) begin
          bcd_next   = digits_shifted;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.ready     = (state_reg == IDLE);
  assign bus.done_tick = (state_reg == DONE);
  assign bus.bcd       = bcd_reg;

endmodule

// File: tb/tb_fib_bin2bcd.sv
// Self-checking bench for fib_bin2bcd: expected BCD values are pushed to a
// scoreboard queue on each accepted start and popped on each done_tick.
module tb_fib_bin2bcd;

  localparam int W  = 20;
  localparam int ND = 7;

  logic clk;
  logic reset;

  int errors = 0;
  int checks = 0;
  int done_count = 0;
  int cyc = 0;

  logic [4*ND-1:0] exp_q[$];

  fib_bin2bcd_if #(.W(W), .ND(ND)) bus ();

  fib_bin2bcd #(.W(W), .ND(ND)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter and done_tick pulse counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.done_tick === 1'b1) done_count <= done_count + 1;
  end

  // Reference conversion by repeated division.
  function automatic logic [4*ND-1:0] to_bcd(input int unsigned v);
    logic [4*ND-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; optionally record the expected result.
  task automatic start_conv(input int unsigned v, input bit push);
    bus.start = 1'b1;
    bus.bin   = W'(v);
    if (push) exp_q.push_back(to_bcd(v));
    tick();
    bus.start = 1'b0;
    bus.bin   = W'($urandom);
  endtask

  // Advance until done_tick is visible or the budget runs out.
  task automatic wait_done(input int budget, output bit seen, output int n);
    n = 0;
    while (bus.done_tick !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    seen = (bus.done_tick === 1'b1);
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    bus.start = 1'b1;
    bus.bin   = W'(12345);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.ready !== 1'b1) begin
        errors++; $display("FAIL reset_ready cyc%0d: got %b want 1", i, bus.ready);
      end
      checks++;
      if (bus.done_tick !== 1'b0) begin
        errors++; $display("FAIL reset_done cyc%0d: got %b want 0", i, bus.done_tick);
      end
      checks++;
      if (bus.bcd !== '0) begin
        errors++; $display("FAIL reset_bcd cyc%0d: got %h want 0000000", i, bus.bcd);
      end
    end
    bus.start = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.ready !== 1'b1 || done_count !== 0) begin
      errors++; $display("FAIL reset_release: ready=%b dones=%0d want ready=1 dones=0", bus.ready, done_count);
    end
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    bit seen;
    int n;
    int d0;
    logic [4*ND-1:0] exp;
    d0 = done_count;
    start_conv(9999, 1'b1);
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++; $display("FAIL basic_ready_busy: got %b want 0", bus.ready);
    end
    wait_done(40, seen, n);
    checks++;
    if (!seen || n != W) begin
      errors++; $display("FAIL basic_latency: seen=%b cycles=%0d want 1/%0d", seen, n, W);
    end
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++; $display("FAIL basic_ready_done: got %b want 0", bus.ready);
    end
    exp = exp_q.size() > 0 ? exp_q.pop_front() : '1;
    checks++;
    if (bus.bcd !== exp) begin
      errors++; $display("FAIL basic_bcd: got %h want %h", bus.bcd, exp);
    end
    tick();
    checks++;
    if (bus.done_tick !== 1'b0 || bus.ready !== 1'b1 || done_count != d0 + 1) begin
      errors++; $display("FAIL basic_after: done=%b ready=%b pulses=%0d want 0/1/%0d",
                         bus.done_tick, bus.ready, done_count - d0, 1);
    end
    $display("test_basic: bin=9999 bcd=%h", bus.bcd);
  endtask

  task automatic test_boundaries();
    int unsigned vals[3] = '{0, 1048575, 6765};
    bit seen;
    int n;
    int d0;
    logic [4*ND-1:0] prev;
    logic [4*ND-1:0] exp;
    for (int k = 0; k < 3; k++) begin
      d0   = done_count;
      prev = bus.bcd;
      start_conv(vals[k], 1'b1);
      repeat (5) tick();
      checks++;
      if (bus.bcd !== prev) begin
        errors++; $display("FAIL bound_hold[%0d]: got %h want %h", k, bus.bcd, prev);
      end
      wait_done(40, seen, n);
      exp = exp_q.size() > 0 ? exp_q.pop_front() : '1;
      checks++;
      if (!seen || bus.bcd !== exp) begin
        errors++; $display("FAIL bound_bcd[%0d]: seen=%b got %h want %h", k, seen, bus.bcd, exp);
      end
      tick();
      tick();
      checks++;
      if (done_count != d0 + 1) begin
        errors++; $display("FAIL bound_pulses[%0d]: got %0d want 1", k, done_count - d0);
      end
      $display("test_boundaries: bin=%0d bcd=%h", vals[k], bus.bcd);
    end
  endtask

  task automatic test_busy_ignore();
    bit seen;
    int n;
    int d0;
    logic [4*ND-1:0] exp;
    d0 = done_count;
    start_conv(4181, 1'b1);
    repeat (3) tick();
    bus.start = 1'b1;
    bus.bin   = W'(999);
    tick();
    bus.start = 1'b0;
    wait_done(40, seen, n);
    bus.start = 1'b1;
    bus.bin   = W'(999);
    tick();
    bus.start = 1'b0;
    exp = exp_q.size() > 0 ? exp_q.pop_front() : '1;
    checks++;
    if (!seen || bus.bcd !== exp) begin
      errors++; $display("FAIL busy_bcd: seen=%b got %h want %h", seen, bus.bcd, exp);
    end
    repeat (30) tick();
    checks++;
    if (done_count != d0 + 1 || bus.ready !== 1'b1 || bus.bcd !== exp) begin
      errors++; $display("FAIL busy_single: pulses=%0d ready=%b bcd=%h want 1/1/%h",
                         done_count - d0, bus.ready, bus.bcd, exp);
    end
    $display("test_busy_ignore: bcd=%h", bus.bcd);
  endtask

  task automatic test_reset_mid();
    bit seen;
    int n;
    int d0;
    logic [4*ND-1:0] exp;
    d0 = done_count;
    start_conv(832040, 1'b0);
    repeat (8) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (bus.ready !== 1'b1 || bus.done_tick !== 1'b0 || bus.bcd !== '0) begin
      errors++; $display("FAIL midreset_state: ready=%b done=%b bcd=%h want 1/0/0000000",
                         bus.ready, bus.done_tick, bus.bcd);
    end
    repeat (25) tick();
    checks++;
    if (done_count != d0 || bus.bcd !== '0) begin
      errors++; $display("FAIL midreset_abort: pulses=%0d bcd=%h want 0/0000000", done_count - d0, bus.bcd);
    end
    start_conv(75025, 1'b1);
    wait_done(40, seen, n);
    exp = exp_q.size() > 0 ? exp_q.pop_front() : '1;
    checks++;
    if (!seen || n != W || bus.bcd !== exp) begin
      errors++; $display("FAIL midreset_restart: seen=%b cycles=%0d got %h want %h", seen, n, bus.bcd, exp);
    end
    tick();
    $display("test_reset_mid: restart bcd=%h", bus.bcd);
  endtask

  task automatic test_back_to_back();
    bit seen;
    int n;
    int t1;
    int t2;
    logic [4*ND-1:0] exp;
    bus.start = 1'b1;
    bus.bin   = W'(10946);
    exp_q.push_back(to_bcd(10946));
    tick();
    bus.bin = W'(17711);
    exp_q.push_back(to_bcd(17711));
    wait_done(40, seen, n);
    t1  = cyc;
    exp = exp_q.size() > 0 ? exp_q.pop_front() : '1;
    checks++;
    if (!seen || bus.bcd !== exp) begin
      errors++; $display("FAIL b2b_first: seen=%b got %h want %h", seen, bus.bcd, exp);
    end
    tick();
    tick();
    bus.start = 1'b0;
    wait_done(40, seen, n);
    t2  = cyc;
    exp = exp_q.size() > 0 ? exp_q.pop_front() : '1;
    checks++;
    if (!seen || bus.bcd !== exp) begin
      errors++; $display("FAIL b2b_second: seen=%b got %h want %h", seen, bus.bcd, exp);
    end
    checks++;
    if (t2 - t1 != W + 2) begin
      errors++; $display("FAIL b2b_spacing: got %0d want %0d", t2 - t1, W + 2);
    end
    repeat (30) tick();
    $display("test_back_to_back: spacing=%0d bcd=%h", t2 - t1, bus.bcd);
  endtask

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0 || done_count != 8) begin
      errors++; $display("FAIL final_scoreboard: pending=%0d pulses=%0d want 0/8", exp_q.size(), done_count);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
